// File: rtl/mips_instruction_memory_pkg.sv
// -----------------------------------------------------------------------------
// mips_instruction_memory_pkg
// Shared constants and types for the MIPS instruction memory:
//   - Instruction_Width          : default instruction word width
//   - Instruction_Mem_Depth      : default number of instruction words
//   - Instruction_Mem_Addr_Width : default word-address width
//   - Default_Nop_Word           : word returned for out-of-range fetches
//   - imem_state_t               : RUN / LOAD control state
// -----------------------------------------------------------------------------
package mips_instruction_memory_pkg;

    localparam int Instruction_Width          = 32;
    localparam int Instruction_Mem_Depth      = 256;
    localparam int Instruction_Mem_Addr_Width = $clog2(Instruction_Mem_Depth);

    localparam logic [31:0] Default_Nop_Word = 32'h0000_0000;

    typedef enum logic [0:0] {
        IMEM_RUN  = 1'b0,
        IMEM_LOAD = 1'b1
    } imem_state_t;

endpackage

// File: rtl/mips_imem_array.sv
// -----------------------------------------------------------------------------
// mips_imem_array
// Single-write-port, single-registered-read-port storage array intended to map
// onto block RAM. The storage itself has no reset; only the read output
// register is cleared by rst_n so the response data is defined after reset.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   write word address (must be < DEPTH)
//   i_wdata  in   write data
//   i_re     in   read enable; read register holds its value when low
//   i_raddr  in   read word address (must be < DEPTH when i_re is high)
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module mips_imem_array
    import mips_instruction_memory_pkg::*;
#(
    parameter int    DATA_W    = Instruction_Width,
    parameter int    DEPTH     = Instruction_Mem_Depth,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage write port (no reset so the array stays RAM-inferable).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds the last word while no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_instruction_memory.sv
// -----------------------------------------------------------------------------
// mips_instruction_memory
// Writable instruction memory with a registered read port, valid/ready
// handshakes on request and response, pipeline flush, and a sequential load
// port for run-time reprogramming.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake, req_addr = word address
//   rsp_valid/rsp_ready response handshake, rsp_data = word,
//                       rsp_err = request address was >= DEPTH
//   flush               drop pending response, refuse requests this cycle
//   ld_start            enter load mode (also drops pending response)
//   ld_valid/ld_data    load word stream, ld_last marks the final word
//   ld_done             one-cycle pulse after the final load write
//   busy                high while in load mode
// -----------------------------------------------------------------------------
module mips_instruction_memory
    import mips_instruction_memory_pkg::*;
#(
    parameter int                DATA_W    = Instruction_Width,
    parameter int                DEPTH     = Instruction_Mem_Depth,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter string             INIT_FILE = "",
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(Default_Nop_Word)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic              busy
);

    // One extra bit so DEPTH itself is representable for the range check.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    imem_state_t       r_state;
    imem_state_t       w_next_state;
    logic [ADDR_W-1:0] r_ld_cnt;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_ld_done;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_addr_oob;
    logic              w_rd_en;
    logic              w_ld_write;
    logic              w_ld_final;
    logic              w_busy;
    logic [DATA_W-1:0] w_rd_data;

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IMEM_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: RUN enters LOAD on ld_start, LOAD exits on the final write.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IMEM_RUN: begin
                if (ld_start) begin
                    w_next_state = IMEM_LOAD;
                end else begin
                    w_next_state = IMEM_RUN;
                end
            end
            IMEM_LOAD: begin
                if (w_ld_final) begin
                    w_next_state = IMEM_RUN;
                end else begin
                    w_next_state = IMEM_LOAD;
                end
            end
            default: w_next_state = IMEM_RUN;
        endcase
    end

    // Per-state control decode: handshake readiness and load write strobes.
    always_comb begin
        w_busy      = 1'b0;
        w_ld_write  = 1'b0;
        w_ld_final  = 1'b0;
        w_req_ready = 1'b0;
        case (r_state)
            IMEM_RUN: begin
                // A pending response blocks acceptance unless it drains this cycle.
                w_req_ready = !flush && !ld_start && (!r_rsp_valid || rsp_ready);
            end
            IMEM_LOAD: begin
                w_busy     = 1'b1;
                w_ld_write = ld_valid;
                // Exit on ld_last or when the top word has been written.
                w_ld_final = ld_valid && (ld_last || (r_ld_cnt == LAST_ADDR));
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
        w_accept   = req_valid && w_req_ready;
        w_addr_oob = ({1'b0, req_addr} >= DEPTH_EXT);
        // Out-of-range requests never touch the array; rsp_err selects NOP_WORD.
        w_rd_en    = w_accept && !w_addr_oob;
    end

    // Load write counter, held at 0 outside LOAD so every load starts at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt <= '0;
        end else if (r_state != IMEM_LOAD) begin
            r_ld_cnt <= '0;
        end else if (w_ld_write) begin
            r_ld_cnt <= r_ld_cnt + ADDR_W'(1);
        end
    end

    // Completion pulse, rising on the same edge that returns the FSM to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_done <= 1'b0;
        end else begin
            r_ld_done <= w_ld_final;
        end
    end

    // Response valid/err: flush and ld_start drop the response; otherwise a new
    // acceptance replaces it, a consumed one clears, and an unconsumed one holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (flush || ld_start) begin
            r_rsp_valid <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_addr_oob;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    mips_imem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ld_write),
        .i_waddr (r_ld_cnt),
        .i_wdata (ld_data),
        .i_re    (w_rd_en),
        .i_raddr (req_addr),
        .o_rdata (w_rd_data)
    );

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_err ? NOP_WORD : w_rd_data;
    assign ld_done   = r_ld_done;
    assign busy      = w_busy;

endmodule

// File: tb/tb_mips_instruction_memory.sv
module tb_mips_instruction_memory;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 12;
    localparam int          ADDR_W = 4;
    localparam logic [31:0] NOP    = 32'hDEAD_BEEF;

    typedef struct {
        logic        ld_start;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        ld_last;
        logic        req_valid;
        logic [3:0]  req_addr;
        logic        rsp_ready;
        logic        flush;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              flush;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_done;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model: spec-level view of the memory and the one-deep response slot.
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_load;
    int          m_cnt;
    bit          m_valid;
    bit          m_err;
    bit          m_done;
    bit          m_dknown;
    logic [31:0] m_data;

    vec_t tbl[$];

    mips_instruction_memory #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (""),
        .NOP_WORD  (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_done   (ld_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic lv, input logic [31:0] ld,
                                input logic ll, input logic rv, input logic [3:0] ad,
                                input logic rr, input logic fl, input logic er,
                                input logic ev, input logic [31:0] ed, input logic ee,
                                input logic eb, input logic edn);
        vec_t v;
        v.ld_start = st; v.ld_valid = lv; v.ld_data = ld; v.ld_last = ll;
        v.req_valid = rv; v.req_addr = ad; v.rsp_ready = rr; v.flush = fl;
        v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_err = ee;
        v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    function automatic bit model_ready(input vec_t v);
        return !m_load && !v.flush && !v.ld_start && (!m_valid || v.rsp_ready);
    endfunction

    task automatic model_reset();
        m_load = 1'b0; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
        m_done = 1'b0; m_data = 32'h0; m_dknown = 1'b1;
    endtask

    task automatic model_step(input vec_t v, input bit rdy);
        bit acc;
        acc    = v.req_valid && rdy;
        m_done = 1'b0;
        if (!m_load) begin
            if (v.ld_start) begin
                m_load = 1'b1;
                m_cnt  = 0;
            end
        end else if (v.ld_valid) begin
            m_mem[m_cnt]   = v.ld_data;
            m_known[m_cnt] = 1'b1;
            if (v.ld_last || m_cnt == DEPTH - 1) begin
                m_load = 1'b0;
                m_done = 1'b1;
            end
            m_cnt++;
        end
        if (v.flush || v.ld_start) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_err   = (int'(v.req_addr) >= DEPTH);
            if (m_err) begin
                m_data   = NOP;
                m_dknown = 1'b1;
            end else begin
                m_data   = m_mem[v.req_addr];
                m_dknown = m_known[v.req_addr];
            end
        end else if (v.rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs checked.
    task automatic apply(input vec_t v, input bit use_model);
        bit rdy;
        ld_start  = v.ld_start;  ld_valid = v.ld_valid; ld_data = v.ld_data;
        ld_last   = v.ld_last;   req_valid = v.req_valid; req_addr = v.req_addr;
        rsp_ready = v.rsp_ready; flush = v.flush;
        @(negedge clk);
        rdy = model_ready(v);
        chk("req_ready", {31'h0, req_ready}, {31'h0, use_model ? rdy : v.e_ready});
        @(posedge clk);
        model_step(v, rdy);
        #1;
        if (use_model) begin
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
            chk("busy", {31'h0, busy}, {31'h0, m_load});
            chk("ld_done", {31'h0, ld_done}, {31'h0, m_done});
            if (m_valid) begin
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
                if (m_dknown) chk("rsp_data", rsp_data, m_data);
            end
        end else begin
            chk("tbl_rsp_valid", {31'h0, rsp_valid}, {31'h0, v.e_valid});
            chk("tbl_busy", {31'h0, busy}, {31'h0, v.e_busy});
            chk("tbl_ld_done", {31'h0, ld_done}, {31'h0, v.e_done});
            if (v.e_valid) begin
                chk("tbl_rsp_err", {31'h0, rsp_err}, {31'h0, v.e_err});
                chk("tbl_rsp_data", rsp_data, v.e_data);
            end
        end
    endtask

    initial begin
        logic [31:0] midrst_exp [4];
        vec_t        v;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

        // Reset values
        #2;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_ld_done", {31'h0, ld_done}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: load A0..A3, stream reads, out-of-range, back-pressure,
        // flush, load with pending response, full-depth auto-exit load.
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b1, 32'hA0 + i, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hA3, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'(i), 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < DEPTH - 1; i++)
            tbl.push_back(mk(1'b0, 1'b1, 32'hB0 + i, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hBB, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 32'hFF, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBB, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        foreach (tbl[i]) apply(tbl[i], 1'b0);

        // Reset in the middle of a 4-word load after 2 words.
        apply(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b1);
        apply(mk(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b1);
        apply(mk(1'b0, 1'b1, 32'hC1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b1);
        ld_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_ld_done", {31'h0, ld_done}, 32'h0);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        midrst_exp[0] = 32'hC0; midrst_exp[1] = 32'hC1;
        midrst_exp[2] = 32'hB2; midrst_exp[3] = 32'hB3;
        for (int k = 0; k < 4; k++) begin
            apply(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'(k), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0), 1'b1);
            chk("midrst_mem", rsp_data, midrst_exp[k]);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            v = mk(($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0), $urandom,
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                   4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 15) == 0), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            apply(v, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
